demux_1x3_reg: RTL and testbench

Registered 1-to-3 demultiplexer with valid/ready handshaking, the dispatch counterpart of the 3-to-1 select muxes in the FPU add/sub datapath. It accepts one W-bit word per transfer with a 2-bit `ctrl` destination code and delivers the word to exactly one of three output channels. Each channel has its own one-entry holding register. Code `2'b11` is invalid: the word is discarded and counted. The block sits between the FPU interface front end and the three operand/result consumers, so a stalled consumer blocks only traffic addressed to it.

---
 rtl/demux_1x3_reg.sv | 55 +++++
 tb/tb_demux_1x3_reg.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/demux_1x3_reg.sv
// demux_1x3_reg: registered 1-to-3 demux with per-channel one-entry buffers and a saturating drop counter
module demux_1x3_reg #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ctrl,
  input  logic [W-1:0]  D,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  S0,
  output logic [W-1:0]  S1,
  output logic [W-1:0]  S2,
  output logic [2:0]    out_valid,
  input  logic [2:0]    out_ready,
  output logic [CW-1:0] drop_cnt,
  output logic          busy
);
  logic [2:0]    out_valid_q, out_valid_d, wr;
  logic [W-1:0]  s_q [3];
  logic [W-1:0]  s_d [3];
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [3:0]    dec, v_ext, r_ext;
  logic          accept;
  // code 11 maps onto a virtual channel that is always empty and ready
  assign v_ext    = {1'b0, out_valid_q};
  assign r_ext    = {1'b1, out_ready};
  assign in_ready = ~v_ext[ctrl] | r_ext[ctrl];
  always_comb begin
    accept      = in_valid & in_ready;
    dec         = 4'b0001 << ctrl;
    wr          = {3{accept}} & dec[2:0];
    out_valid_d = wr | (out_valid_q & ~out_ready);
    for (int k = 0; k < 3; k++) s_d[k] = wr[k] ? D : s_q[k];
    drop_cnt_d  = (accept & dec[3] & ~&drop_cnt_q) ? drop_cnt_q + CW'(1) : drop_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= '0;
      drop_cnt_q  <= '0;
      for (int k = 0; k < 3; k++) s_q[k] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      drop_cnt_q  <= drop_cnt_d;
      for (int k = 0; k < 3; k++) s_q[k] <= s_d[k];
    end
  end
  assign S0        = s_q[0];
  assign S1        = s_q[1];
  assign S2        = s_q[2];
  assign out_valid = out_valid_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = |out_valid_q;
endmodule

// File: tb/tb_demux_1x3_reg.sv
// tb_demux_1x3_reg: directed checks plus a scoreboard soak for demux_1x3_reg (CW=4 to reach saturation)
module tb_demux_1x3_reg;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, busy;
  logic [1:0] ctrl;
  logic [7:0] D, S0, S1, S2;
  logic [2:0] out_valid, out_ready;
  logic [3:0] drop_cnt;
  int checks = 0, failures = 0;

  demux_1x3_reg #(.W(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .D(D), .in_valid(in_valid), .in_ready(in_ready),
    .S0(S0), .S1(S1), .S2(S2), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q [3][$];
  logic [7:0] s_now [3];
  logic [7:0] exp_w;
  int         drops;
  logic       exp_ir;

  initial begin
    rst = 1'b0; in_valid = 1'b0; ctrl = 2'b00; D = 8'h00; out_ready = 3'b000;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_s0", 32'(S0), 0);
    check("rst_s1", 32'(S1), 0);
    check("rst_s2", 32'(S2), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    // route A5 to ch1
    rst = 1'b1; in_valid = 1'b1; ctrl = 2'b01; D = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("route_valid", 32'(out_valid), 32'b010);
    check("route_s1", 32'(S1), 32'hA5);
    check("route_busy", 32'(busy), 1);
    ctrl = 2'b00; #1;
    check("route_ir_ch0", 32'(in_ready), 1);
    ctrl = 2'b01; #1;
    check("route_ir_ch1_full", 32'(in_ready), 0);
    // stall isolation on ch0
    in_valid = 1'b1; ctrl = 2'b00; D = 8'h77;
    tick();
    D = 8'h99; #1;
    check("stall_ir_ch0", 32'(in_ready), 0);
    tick();
    check("stall_s0_kept", 32'(S0), 32'h77);
    check("stall_valid", 32'(out_valid), 32'b011);
    ctrl = 2'b10; D = 8'h3C; #1;
    check("stall_ir_ch2", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("stall_s2", 32'(S2), 32'h3C);
    check("stall_valid2", 32'(out_valid), 32'b111);
    // pass-through on ch2
    out_ready = 3'b100;
    tick();
    check("drain_ch2", 32'(out_valid), 32'b011);
    out_ready = 3'b000; in_valid = 1'b1; ctrl = 2'b10; D = 8'h11;
    tick();
    check("pt_load", 32'(S2), 32'h11);
    out_ready = 3'b100; D = 8'h22; #1;
    check("pt_ir", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; out_ready = 3'b000;
    check("pt_s2", 32'(S2), 32'h22);
    check("pt_valid", 32'(out_valid), 32'b111);
    check("pt_s0_untouched", 32'(S0), 32'h77);
    // drop saturation
    out_ready = 3'b111;
    tick();
    check("drain_all", 32'(out_valid), 0);
    check("drain_busy", 32'(busy), 0);
    out_ready = 3'b000; in_valid = 1'b1; ctrl = 2'b11;
    for (int i = 1; i <= 17; i++) begin
      D = 8'(i); #1;
      check("drop_ir", 32'(in_ready), 1);
      tick();
      check("drop_cnt", 32'(drop_cnt), (i > 15) ? 15 : i);
      check("drop_valid", 32'(out_valid), 0);
    end
    check("drop_s1_kept", 32'(S1), 32'hA5);
    // reset mid-operation
    for (int k = 0; k < 3; k++) begin
      ctrl = 2'(k); D = 8'hC0 + 8'(k);
      tick();
    end
    check("fill_valid", 32'(out_valid), 32'b111);
    check("fill_s1", 32'(S1), 32'hC1);
    rst = 1'b0; ctrl = 2'b00; D = 8'hEE; out_ready = 3'b111;
    tick();
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_s0", 32'(S0), 0);
    check("mrst_s1", 32'(S1), 0);
    check("mrst_s2", 32'(S2), 0);
    check("mrst_drop", 32'(drop_cnt), 0);
    // random soak against a per-channel FIFO scoreboard
    rst = 1'b1; in_valid = 1'b0; out_ready = 3'b000;
    drops = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      ctrl      = 2'($urandom_range(0, 3));
      D         = 8'($urandom);
      out_ready = 3'($urandom);
      #1;
      s_now[0] = S0; s_now[1] = S1; s_now[2] = S2;
      exp_ir = (ctrl == 2'b11) ? 1'b1 : ((q[ctrl].size() == 0) || out_ready[ctrl]);
      check("soak_ir", 32'(in_ready), 32'(exp_ir));
      for (int k = 0; k < 3; k++) begin
        check("soak_valid", 32'(out_valid[k]), 32'(q[k].size() != 0));
        if (out_valid[k] && out_ready[k] && q[k].size() != 0) begin
          exp_w = q[k].pop_front();
          check("soak_data", 32'(s_now[k]), 32'(exp_w));
        end
      end
      if (in_valid && exp_ir) begin
        if (ctrl == 2'b11) drops = (drops == 15) ? 15 : drops + 1;
        else q[ctrl].push_back(D);
      end
      tick();
      check("soak_drop", 32'(drop_cnt), 32'(drops));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
